// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// FSM state encoding and default operand width.
package mult_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add step of the multiplier, purely combinational.
// Adds the multiplicand into the upper half when the LSB is set, then shifts right.
module mult_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] addend,
  output logic [2*WIDTH:0] nxt
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;

  // conditional add keeps the carry in the top bit, then shift right by one
  always_comb begin
    upper = acc[2*WIDTH:WIDTH];
    sum   = acc[0] ? upper + {1'b0, addend} : upper;
    nxt   = {1'b0, sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/param_seq_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, one step per clock.
// Optional signed operation is enabled by defining MULT_SIGNED_EN.
module param_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [2*WIDTH-1:0] result;
  logic               accept;
  logic               last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc    (acc),
    .addend (mag_a),
    .nxt    (acc_nxt)
  );

`ifdef MULT_SIGNED_EN
  logic neg;
  logic a_neg;
  logic b_neg;

  // operand magnitudes and result sign for two's-complement mode
  always_comb begin
    a_neg    = signed_mode & multiplicand[WIDTH-1];
    b_neg    = signed_mode & multiplier[WIDTH-1];
    mag_a_in = a_neg ? -multiplicand : multiplicand;
    mag_b_in = b_neg ? -multiplier : multiplier;
    result   = neg ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];
  end

  // sign of the pending result, captured with the operands
  always_ff @(posedge clk) begin
    if (reset)
      neg <= 1'b0;
    else if (accept)
      neg <= a_neg ^ b_neg;
  end
`else
  logic signed_mode_unused;

  assign signed_mode_unused = signed_mode;

  // unsigned only: operands pass straight through
  always_comb begin
    mag_a_in = multiplicand;
    mag_b_in = multiplier;
    result   = acc_nxt[2*WIDTH-1:0];
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic; DONE may chain straight into a new operation
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (last) state_nxt = DONE;
      DONE: state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, step counter, accumulator and product register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      mag_a   <= '0;
      product <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mag_a <= mag_a_in;
      acc   <= {{(WIDTH + 1){1'b0}}, mag_b_in};
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_nxt;
      if (last)
        product <= result;
    end
  end

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Directed bench for param_seq_multiplier at WIDTH = 16.
// Signed vectors are included only when MULT_SIGNED_EN is defined.
module tb_param_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  param_seq_multiplier #(
    .WIDTH (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Starts an operation at the current negedge (cycle 0) and follows it
  // until done. poke > 0 re-asserts start with 7 x 7 at that cycle.
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic [31:0] exp,
                          input int poke, input string nm);
    logic [31:0] prev;
    int          bc;
    int          lat;
    int          unstable;
    prev         = product;
    bc           = 0;
    lat          = 0;
    unstable     = 0;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sgn;
    start        = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (poke > 0 && k == poke) begin
        start        = 1'b1;
        multiplicand = 16'd7;
        multiplier   = 16'd7;
      end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (busy) bc++;
      if (done) lat = k;
      else if (product !== prev) unstable++;
    end
    chk({nm, " latency"}, lat, 32'd17);
    chk({nm, " busy_cycles"}, bc, 32'd16);
    chk({nm, " held_during_busy"}, unstable, 32'd0);
    chk({nm, " product"}, product, exp);
  endtask

  initial begin
    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 32'h0000000F});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
    vecs.push_back('{16'h0000, 16'hFFFF, 1'b0, 32'h00000000});
    vecs.push_back('{16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF});
    vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000});
    vecs.push_back('{16'h1000, 16'h1000, 1'b0, 32'h01000000});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
    vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1});
    vecs.push_back('{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1});
`else
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 32'h00008000});
`endif

    reset        = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset product", product, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_mult(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, 0,
               $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), done, 0);
      chk($sformatf("vec%0d idle_busy", i), busy, 0);
      chk($sformatf("vec%0d product_held", i), product, vecs[i].exp);
    end

    run_mult(16'd3, 16'd5, 1'b0, 32'h0000000F, 5, "ignore_start");
    @(negedge clk);
    chk("ignore_start idle", {busy, done}, 0);

    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start        = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 8) reset = 1'b1;
    end
    @(negedge clk);
    chk("midop_reset busy", busy, 0);
    chk("midop_reset done", done, 0);
    chk("midop_reset product", product, 0);
    reset = 1'b0;
    begin
      int act;
      act = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy || done) act++;
      end
      chk("midop_reset no_done", act, 0);
    end
    run_mult(16'd2, 16'd2, 1'b0, 32'h00000004, 0, "after_reset");
    @(negedge clk);

    run_mult(16'd3, 16'd5, 1'b0, 32'h0000000F, 0, "b2b_first");
    run_mult(16'd6, 16'd7, 1'b0, 32'h0000002A, 0, "b2b_second");
    repeat (3) @(negedge clk);
    chk("b2b idle", {busy, done}, 0);
    chk("b2b product_held", product, 32'h0000002A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_seq_multiplier.md
PARAM_SEQ_MULTIPLIER -- requirements
Module: param_seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal 4..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning step-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a multiplication.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-008 SHALL have port multiplier  input  WIDTH  operand B.
REQ-009 SHALL have port busy  output  1  high while shift-add steps run.
REQ-010 SHALL have port done  output  1  one-cycle pulse when product becomes valid.
REQ-011 SHALL have port product  output  2*WIDTH  result, held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; the accepting edge latches operands and signed_mode, clears the accumulator, sets counter to 0, enters BUSY.
REQ-014 SHALL, in BUSY, perform one shift-add step per cycle: if accumulator LSB is 1 add latched magnitude of A into the upper half (WIDTH+1-bit sum, carry kept), then shift the 2*WIDTH+1 register right by one.
REQ-015 SHALL execute exactly WIDTH steps, then enter DONE; latency from accepting edge to done high is WIDTH+1 cycles.
REQ-016 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE unless start is high in that cycle (back-to-back accept).
REQ-017 SHALL ignore start while in BUSY; operands and product are unaffected.
REQ-018 SHALL update product only on the DONE-entry edge; product is stable at all other times.
REQ-019 SHALL hold busy = 1 exactly in BUSY, done = 1 exactly in DONE.
REQ-020 SHALL produce the full 2*WIDTH-bit result with no overflow or truncation for any operand pair.
REQ-021 SHALL treat operand changes after the accepting edge as don't-care.

Reset
REQ-022 SHALL on reset (any state, including mid-BUSY) enter IDLE, clear counter, accumulator and product to 0, drive busy = 0, done = 0; an operation in progress is abandoned with no done pulse.
REQ-023 SHALL, when reset and start are both high, give reset priority.

Configuration
REQ-024 SHALL support macro MULT_SIGNED_EN: when defined, signed_mode = 1 multiplies magnitudes of A and B and two's-complement negates the 2*WIDTH result when operand signs differ, in the DONE-entry edge (latency unchanged).
REQ-025 SHALL, when MULT_SIGNED_EN is undefined, ignore signed_mode and always multiply unsigned; no negation logic is synthesised.

Structure
REQ-026 SHALL place the FSM state enum/localparams (IDLE, BUSY, DONE) and the default WIDTH constant in shared package mult_pkg.
REQ-027 SHALL isolate one shift-add step (conditional add + right shift, combinational, WIDTH-parametrised) in sub-module mult_step; the FSM, counter and registers stay in param_seq_multiplier.

Verification (WIDTH = 16)
REQ-028 SHALL cover: unsigned 3 x 5, start at cycle 0 -> busy cycles 1..16, done pulse at cycle 17, product = 0x0000000F.
REQ-029 SHALL cover: unsigned 0xFFFF x 0xFFFF -> product = 0xFFFE0001; 0 x 0xFFFF -> 0x00000000.
REQ-030 SHALL cover (MULT_SIGNED_EN defined): signed -1 x -1 -> 0x00000001; signed 0x8000 x 1 -> 0xFFFF8000; signed 0x8000 x 0x8000 -> 0x40000000.
REQ-031 SHALL cover: start re-asserted with new operands 7 x 7 at cycle 5 during BUSY -> ignored, first result delivered unchanged at cycle 17.
REQ-032 SHALL cover: reset asserted at cycle 8 of a 3 x 5 operation -> next cycle busy = 0, done = 0, product = 0, no done pulse; subsequent 2 x 2 start -> product 0x00000004 after 17 cycles.
REQ-033 SHALL cover: start held high in the DONE cycle with 6 x 7 -> accepted back-to-back, done again 17 cycles later, product = 0x0000002A.
